// File: rtl/xor_cipher_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xor_cipher_pkg
// Brief   : Shared FSM state encoding and default chain length for the
//           XOR cipher configuration controller.
// Revision: 1.0
// ============================================================================
package xor_cipher_pkg;

    localparam int M_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_COLLECT    = 3'd1,
        ST_LOAD_SHIFT = 3'd2,
        ST_VERIFY     = 3'd3,
        ST_READY      = 3'd4,
        ST_RUN        = 3'd5,
        ST_ERR        = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/xor_cipher_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : xor_cipher_ctrl
// Brief   : Collects a key from the host, shifts it into the cipher config
//           chain, reads it back to verify, then gates cipher streaming.
// Revision: 1.0
// ============================================================================
module xor_cipher_ctrl
    import xor_cipher_pkg::*;
#(
    parameter int M = M_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_byte,
    input  logic       key_wr,
    output logic       key_rdy,
    input  logic       run,
    output logic       cfg_en,
    output logic       cfg_i,
    input  logic       cfg_o,
    output logic       tx_en,
    output logic       rx_en,
    output logic       busy,
    output logic       cfg_ok,
    output logic       cfg_err
);

    localparam int              CW          = $clog2(M) + 1;
    localparam int              NBYTES      = M / 8;
    localparam logic [CW-1:0]   c_LAST_BIT  = CW'(M - 1);
    localparam logic [CW-1:0]   c_LAST_BYTE = CW'(NBYTES - 1);

    state_t          r_state;
    logic [M-1:0]    r_key;
    logic [CW-1:0]   r_cnt;
    logic            r_mis;

    logic [M-1:0]    w_key_next;
    logic [M-1:0]    w_key_rot;
    logic            w_accept;
    logic            w_last_byte;
    logic            w_shift_last;
    logic            w_bit_bad;

    assign w_key_next   = (r_key << 8) | M'(key_byte);
    assign w_key_rot    = {r_key[M-2:0], r_key[M-1]};
    assign w_accept     = key_wr & key_rdy;
    assign w_last_byte  = (r_state == ST_COLLECT) ? (r_cnt == c_LAST_BYTE) : (NBYTES == 1);
    assign w_shift_last = (r_cnt == c_LAST_BIT);
    // cfg_i is the bit presented this cycle, so the chain tail must echo it now
    assign w_bit_bad    = cfg_o ^ cfg_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_cnt   <= '0;
            r_mis   <= 1'b0;
            key_rdy <= 1'b0;
            cfg_en  <= 1'b0;
            cfg_i   <= 1'b0;
            tx_en   <= 1'b0;
            rx_en   <= 1'b0;
            busy    <= 1'b0;
            cfg_ok  <= 1'b0;
            cfg_err <= 1'b0;
        end else if (w_accept) begin
            r_key   <= w_key_next;
            cfg_ok  <= 1'b0;
            cfg_err <= 1'b0;
            tx_en   <= 1'b0;
            rx_en   <= 1'b0;
            if (w_last_byte) begin
                r_state <= ST_LOAD_SHIFT;
                r_cnt   <= '0;
                r_mis   <= 1'b0;
                key_rdy <= 1'b0;
                busy    <= 1'b1;
                cfg_en  <= 1'b1;
                cfg_i   <= w_key_next[M-1];
            end else begin
                // r_cnt counts stored bytes while collecting
                r_state <= ST_COLLECT;
                r_cnt   <= (r_state == ST_COLLECT) ? r_cnt + CW'(1) : CW'(1);
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    key_rdy <= 1'b1;
                end
                ST_READY: begin
                    if (run) begin
                        r_state <= ST_RUN;
                        tx_en   <= 1'b1;
                        rx_en   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        r_state <= ST_READY;
                        tx_en   <= 1'b0;
                        rx_en   <= 1'b0;
                    end
                end
                ST_LOAD_SHIFT: begin
                    // M rotations restore the key for the verify pass
                    r_key <= w_key_rot;
                    cfg_i <= r_key[M-2];
                    if (w_shift_last) begin
                        r_state <= ST_VERIFY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_VERIFY: begin
                    r_key <= w_key_rot;
                    r_mis <= r_mis | w_bit_bad;
                    if (w_shift_last) begin
                        cfg_en  <= 1'b0;
                        cfg_i   <= 1'b0;
                        busy    <= 1'b0;
                        key_rdy <= 1'b1;
                        if (r_mis | w_bit_bad) begin
                            r_state <= ST_ERR;
                            cfg_err <= 1'b1;
                        end else begin
                            r_state <= ST_READY;
                            cfg_ok  <= 1'b1;
                        end
                    end else begin
                        cfg_i <= r_key[M-2];
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/xor_cipher_ctrl.md
XOR_CIPHER_CTRL -- requirements
Module: xor_cipher_ctrl

Interface
REQ-001 SHALL have parameter: M, 32, cipher config-chain length in bits; legal values are multiples of 8, from 8 to 64.
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset; synchronous and active-low.
REQ-004 SHALL have port: key_byte  in  8  key/seed byte from the host.
REQ-005 SHALL have port: key_wr  in  1  key_byte write strobe; accepted only in a cycle where key_rdy=1.
REQ-006 SHALL have port: key_rdy  out  1  controller accepts key bytes.
REQ-007 SHALL have port: run  in  1  level request to stream data through the cipher.
REQ-008 SHALL have port: cfg_en  out  1  cipher config-chain shift enable.
REQ-009 SHALL have port: cfg_i  out  1  serial config bit to the cipher.
REQ-010 SHALL have port: cfg_o  in  1  serial config bit from the cipher; combinational chain tail.
REQ-011 SHALL have ports: tx_en, rx_en  out  1 each  cipher transmit/receive enables.
REQ-012 SHALL have port: busy  out  1  high in LOAD_SHIFT and VERIFY.
REQ-013 SHALL have ports: cfg_ok, cfg_err  out  1 each  sticky verify pass/fail flags.

Function
REQ-014 SHALL implement FSM states IDLE, COLLECT, LOAD_SHIFT, VERIFY, READY, RUN, ERR.
REQ-015 SHALL, in IDLE, READY and ERR, drive key_rdy=1; an accepted key_wr moves to COLLECT, clears cfg_ok/cfg_err and stores byte 0.
REQ-016 SHALL, in COLLECT, keep key_rdy=1 and store bytes first-byte-most-significant; on byte M/8 accepted, go to LOAD_SHIFT next cycle.
REQ-017 SHALL, in LOAD_SHIFT, assert cfg_en=1 for exactly M cycles, cfg_i = key bit M-1 down to bit 0, one bit per cycle.
REQ-018 SHALL, in VERIFY, shift the same key again for M cycles, comparing cfg_o each cycle against the key bit being presented in that same cycle.
REQ-019 SHALL, after M matching VERIFY bits, enter READY with cfg_ok=1; on any mismatch, finish the M cycles, then enter ERR with cfg_err=1.
REQ-020 SHALL keep key_rdy=0 during LOAD_SHIFT and VERIFY and ignore key_wr there.
REQ-021 SHALL move READY->RUN when run=1 and RUN->READY when run=0; tx_en=rx_en=1 only in RUN, registered, 1-cycle latency from run.
REQ-022 SHALL ignore run in every state except READY/RUN; run held high through configuration enters RUN on the cycle after READY.
REQ-023 SHALL, on key_wr accepted in RUN, abort streaming (tx_en=rx_en=0 next cycle) and enter COLLECT.
REQ-024 SHALL hold cfg_en=0 and cfg_i=0 outside LOAD_SHIFT/VERIFY.
REQ-025 SHALL use a bit counter of width clog2(M)+1 that terminates at M-1 without wrap.

Reset
REQ-026 SHALL, with rst_n=0 at a clock edge, enter IDLE and force key_rdy=0 that cycle, then 1 from IDLE; cfg_en, cfg_i, tx_en, rx_en, busy, cfg_ok, cfg_err all 0.
REQ-027 SHALL let reset mid-shift abandon the key and counters; the cipher chain content is then undefined and only a full reload gives cfg_ok.

Structure
REQ-028 SHALL place the FSM state enum and the default M in a shared package xor_cipher_pkg.
REQ-029 SHALL be a single module with no sub-modules; the key register doubles as a rotate-left shift register so the VERIFY pass reuses it.

Verification
REQ-030 SHALL cover: reset, then bytes 0xDE,0xAD,0xBE,0xEF with an ideal 32-bit chain model -> cfg_i streams 0xDEADBEEF MSB-first over 32 cycles, then cfg_ok=1 after cycle 64.
REQ-031 SHALL cover: chain model with bit 5 stuck at 0 -> cfg_err=1 and cfg_ok=0 after 64 shift cycles, then state ERR with key_rdy=1.
REQ-032 SHALL cover: run=1 held from reset -> tx_en=rx_en=0 until READY, then 1 exactly one cycle later; run=0 -> both 0 next cycle.
REQ-033 SHALL cover: key_wr pulsed during LOAD_SHIFT -> byte ignored and shift sequence unchanged.
REQ-034 SHALL cover: rst_n=0 at shift cycle 10 -> all outputs 0 next cycle; a reload of 0x00000001 passes verify.
REQ-035 SHALL cover: key_wr in RUN -> tx_en=0 next cycle, COLLECT entered, new key loaded and verified.
